// File: rtl/mem_verify_reader_if.sv
// Memory read bus plus the captured-byte valid/ready stream of mem_verify_reader.
// The master modport is the reader; the slave modport is the memory and downstream consumer.
interface mem_verify_reader_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req_n;
  logic              mem_rd_n;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_req_n, mem_rd_n, out_data, out_valid,
    input  mem_din, out_ready
  );

  modport slave (
    input  mem_addr, mem_req_n, mem_rd_n, out_data, out_valid,
    output mem_din, out_ready
  );
endinterface

// File: rtl/mem_verify_reader.sv
// Sequential memory reader: fetches LENGTH bytes from START_ADDR, hands each byte downstream
// and optionally compares it against the (SEED + index) pattern, counting mismatches.
module mem_verify_reader #(
  parameter logic [15:0] START_ADDR = 16'h3C00,
  parameter int unsigned LENGTH     = 1024,
  parameter logic [7:0]  SEED       = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        check_en,
  mem_verify_reader_if.master         bus,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 err_count,
  output logic [15:0]                 first_err_addr
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic                chk_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_req_n_q;
  logic                mem_rd_n_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    err_count_q;
  logic [ADDR_W-1:0]   first_err_addr_q;

  logic [DATA_W-1:0]   exp_byte_c;
  logic                mismatch_c;

  // Expected pattern byte for the current index; only the low byte of the index matters.
  assign exp_byte_c = SEED + DATA_W'(idx_q);
  assign mismatch_c = chk_q && (bus.mem_din != exp_byte_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      cur_addr_q       <= '0;
      chk_q            <= 1'b0;
      mem_addr_q       <= '0;
      mem_req_n_q      <= 1'b1;
      mem_rd_n_q       <= 1'b1;
      out_data_q       <= '0;
      out_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            chk_q            <= check_en;
            idx_q            <= '0;
            cur_addr_q       <= START_ADDR;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            mem_addr_q       <= START_ADDR;
            mem_req_n_q      <= 1'b0;
            mem_rd_n_q       <= 1'b0;
            busy_q           <= 1'b1;
            state_q          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid at this edge: two edges after the address went out.
          out_data_q  <= bus.mem_din;
          out_valid_q <= 1'b1;
          mem_req_n_q <= 1'b1;
          mem_rd_n_q  <= 1'b1;
          if (mismatch_c) begin
            if (err_count_q != '1) begin
              err_count_q <= err_count_q + CNT_W'(1);
            end
            if (err_count_q == '0) begin
              first_err_addr_q <= cur_addr_q;
            end
          end
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q       <= idx_q + IDX_W'(1);
              cur_addr_q  <= cur_addr_q + ADDR_W'(1);
              mem_addr_q  <= cur_addr_q + ADDR_W'(1);
              mem_req_n_q <= 1'b0;
              mem_rd_n_q  <= 1'b0;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_req_n   = mem_req_n_q;
  assign bus.mem_rd_n    = mem_rd_n_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_addr_q;

endmodule

// File: doc/mem_verify_reader.md
MEM_VERIFY_READER -- requirements
Module: mem_verify_reader

Interface
REQ-001 Parameter START_ADDR, default 16'h3C00: first address read.
REQ-002 Parameter LENGTH, default 1024: number of bytes per pass; legal range 1..65536.
REQ-003 Parameter SEED, default 8'h00: expected byte at index i is (SEED + i) mod 256.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock (cpu_clock domain).
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a pass.
REQ-008 check_en  in  1  enable pattern comparison; sampled only when a pass starts.
REQ-009 mem_addr  out  16  memory address.
REQ-010 mem_req_n  out  1  memory request, active low.
REQ-011 mem_rd_n  out  1  memory read strobe, active low.
REQ-012 mem_din  in  8  read data from memory (RAM/ROM/video mux).
REQ-013 out_data  out  8  captured byte.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  downstream accepts out_data.
REQ-016 busy  out  1  pass in progress.
REQ-017 done  out  1  one-cycle pulse at end of pass.
REQ-018 err_count  out  16  mismatch count for the current or last pass.
REQ-019 first_err_addr  out  16  address of the first mismatch in the current or last pass.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
REQ-021 IDLE: if start=1, latch check_en, set idx=0 and cur_addr=START_ADDR, clear err_count and first_err_addr, go to ISSUE; otherwise stay in IDLE.
REQ-022 ISSUE and WAIT: drive mem_addr=cur_addr with mem_req_n=0 and mem_rd_n=0; ISSUE always goes to WAIT.
REQ-023 At the clock edge that ends WAIT:
- latch mem_din into out_data;
- set out_valid=1;
- if check enabled and mem_din != (SEED+idx)[7:0], increment err_count;
- go to HOLD.
REQ-024 Read latency: mem_din is valid at the second rising edge after mem_addr is first driven.
REQ-025 HOLD: drive mem_req_n=1 and mem_rd_n=1; keep mem_addr unchanged; hold out_valid=1 and out_data stable until out_ready=1.
REQ-026 A handshake occurs at any edge where out_valid=1 and out_ready=1, including the first HOLD cycle.
REQ-027 On handshake, out_valid SHALL drop to 0 at that edge.
- If idx==LENGTH-1, go to DONE.
- Otherwise, increment idx and cur_addr and go to ISSUE.
REQ-028 Minimum throughput is 3 cycles per byte.
REQ-029 DONE: assert done=1 for exactly one cycle, then go to IDLE.
REQ-030 busy=1 in ISSUE, WAIT and HOLD; busy=0 in IDLE and DONE.
REQ-031 cur_addr SHALL wrap from 16'hFFFF to 16'h0000.
REQ-032 err_count SHALL saturate at 16'hFFFF.
REQ-033 first_err_addr SHALL be written only on the mismatch that takes err_count from 0 to 1; it is meaningful only when err_count != 0.
REQ-034 start asserted while busy or in DONE SHALL be ignored.
REQ-035 Changes to check_en during a pass SHALL have no effect.
REQ-036 err_count and first_err_addr SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-037 reset=1 SHALL force the following at the next edge, from any state including mid-pass:
- state=IDLE;
- mem_addr=16'h0000, mem_req_n=1, mem_rd_n=1;
- out_data=8'h00, out_valid=0;
- busy=0, done=0;
- err_count=0, first_err_addr=16'h0000.
REQ-038 A start asserted in the same cycle as reset SHALL be ignored.
REQ-039 A pass interrupted by reset SHALL NOT produce a done pulse.

Verification
REQ-040 Clean pass:
- Stimulus: LENGTH=4; memory model returns (addr-16'h3C00)[7:0]; out_ready=1; check_en=1.
- Response: out_data sequence 00,01,02,03; 12 busy cycles; one done pulse; err_count=0.
REQ-041 Corrupt byte:
- Stimulus: as REQ-040, but address 16'h3C02 returns 8'hFF.
- Response: err_count=1; first_err_addr=16'h3C02; out_data sequence 00,01,FF,03.
REQ-042 Backpressure:
- Stimulus: out_ready=0 for 5 cycles after out_valid rises.
- Response: out_valid and out_data held stable; mem_req_n=1 throughout the stall; next address issued the cycle after the handshake.
REQ-043 Address wrap:
- Stimulus: START_ADDR=16'hFFFE, LENGTH=3.
- Response: mem_addr sequence FFFE, FFFF, 0000.
REQ-044 Reset mid-pass:
- Stimulus: reset asserted in HOLD of byte 2.
- Response: next cycle all outputs at reset values; no done pulse; a new start runs a full pass from START_ADDR.
REQ-045 Ignored start and check disabled:
- Stimulus: start pulsed again while busy; check_en=0 with all-wrong data.
- Response: the pass is not restarted; err_count=0 at done.
